// File: rtl/dlbf_slave_rdctrl_if.sv
// Signal bundle between the DLBF RX readback sequencer and its environment:
// session control, slave-side CDC port-B signals and the readout stream.
interface dlbf_slave_rdctrl_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 64
);
   logic              start;
   logic [11:0]       niter_cfg;
   logic              rxdone_bram;
   logic [ADDR_W-1:0] rxram_counter_bram;
   logic [DATA_W-1:0] doutb_bram;
   logic              slave_rst_bram;
   logic [11:0]       niter_bram;
   logic [ADDR_W-1:0] addrb_bram;
   logic              enb_bram;
   logic              web_bram;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              busy;
   logic              done;
   logic              err_timeout;

   modport slave (
      input  start, niter_cfg, rxdone_bram, rxram_counter_bram, doutb_bram, m_ready,
      output slave_rst_bram, niter_bram, addrb_bram, enb_bram, web_bram,
             m_data, m_valid, busy, done, err_timeout
   );

   modport master (
      output start, niter_cfg, rxdone_bram, rxram_counter_bram, doutb_bram, m_ready,
      input  slave_rst_bram, niter_bram, addrb_bram, enb_bram, web_bram,
             m_data, m_valid, busy, done, err_timeout
   );
endinterface

// File: rtl/dlbf_slave_rdctrl.sv
// Readback sequencer for the DLBF slave RX RAM: pulses the slave reset, waits for
// receive-done, then streams every received word out with CDC-paced addr/enable steps.
module dlbf_slave_rdctrl #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned SETTLE_CYC  = 8,
   parameter int unsigned RD_LAT      = 12,
   parameter int unsigned RST_PULSE   = 16,
   parameter int unsigned TIMEOUT_CYC = 1048576
) (
   input  logic               bram_clk_a,
   input  logic               bram_rst_a_n,
   dlbf_slave_rdctrl_if.slave bus
);
   localparam int unsigned NITER_W = 12;
   localparam int unsigned MAX_A   = (SETTLE_CYC > RD_LAT) ? SETTLE_CYC : RD_LAT;
   localparam int unsigned MAX_B   = (MAX_A > RST_PULSE) ? MAX_A : RST_PULSE;
   localparam int unsigned CNT_MAX = (MAX_B > TIMEOUT_CYC) ? MAX_B : TIMEOUT_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_RESET, S_WAIT_CLR, S_WAIT_DONE, S_ADDR, S_READ, S_OUT, S_CLOSE, S_FIN
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [ADDR_W-1:0]   nwords_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [NITER_W-1:0]  niter_q;
   logic [DATA_W-1:0]   data_q;
   logic                slave_rst_q;
   logic                enb_q;
   logic                valid_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;

   logic cnt_rst_end_c, cnt_settle_end_c, cnt_rd_end_c, cnt_tmo_end_c;
   assign cnt_rst_end_c    = (cnt_q == CNT_W'(RST_PULSE - 1));
   assign cnt_settle_end_c = (cnt_q == CNT_W'(SETTLE_CYC - 1));
   assign cnt_rd_end_c     = (cnt_q == CNT_W'(RD_LAT - 1));
   assign cnt_tmo_end_c    = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   // One shared cycle counter paces every timed state; it restarts on each state entry.
   always_ff @(posedge bram_clk_a or negedge bram_rst_a_n) begin
      if (!bram_rst_a_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         nwords_q    <= '0;
         addr_q      <= '0;
         niter_q     <= '0;
         data_q      <= '0;
         slave_rst_q <= 1'b0;
         enb_q       <= 1'b0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  niter_q     <= bus.niter_cfg;
                  err_q       <= 1'b0;
                  slave_rst_q <= 1'b1;
                  busy_q      <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= S_RESET;
               end
            end
            S_RESET: begin
               if (cnt_rst_end_c) begin
                  slave_rst_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= S_WAIT_CLR;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            // A done level left over from the previous session must drain first.
            S_WAIT_CLR: begin
               if (!bus.rxdone_bram) begin
                  cnt_q   <= '0;
                  state_q <= S_WAIT_DONE;
               end else if (cnt_tmo_end_c) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_WAIT_DONE: begin
               if (bus.rxdone_bram) begin
                  nwords_q <= bus.rxram_counter_bram;
                  addr_q   <= '0;
                  cnt_q    <= '0;
                  if (bus.rxram_counter_bram == '0) begin
                     done_q  <= 1'b1;
                     state_q <= S_FIN;
                  end else begin
                     state_q <= S_ADDR;
                  end
               end else if (cnt_tmo_end_c) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_ADDR: begin
               if (cnt_settle_end_c) begin
                  cnt_q   <= '0;
                  enb_q   <= 1'b1;
                  state_q <= S_READ;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_READ: begin
               if (cnt_rd_end_c) begin
                  cnt_q   <= '0;
                  data_q  <= bus.doutb_bram;
                  valid_q <= 1'b1;
                  state_q <= S_OUT;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_OUT: begin
               if (bus.m_ready) begin
                  valid_q <= 1'b0;
                  enb_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= S_CLOSE;
               end
            end
            // Address steps by exactly one, and only while the enable is low.
            S_CLOSE: begin
               if (cnt_settle_end_c) begin
                  cnt_q <= '0;
                  if (addr_q == nwords_q - ADDR_W'(1)) begin
                     done_q  <= 1'b1;
                     state_q <= S_FIN;
                  end else begin
                     addr_q  <= addr_q + ADDR_W'(1);
                     state_q <= S_ADDR;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_FIN: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.slave_rst_bram = slave_rst_q;
   assign bus.niter_bram     = niter_q;
   assign bus.addrb_bram     = addr_q;
   assign bus.enb_bram       = enb_q;
   assign bus.web_bram       = 1'b0;
   assign bus.m_data         = data_q;
   assign bus.m_valid        = valid_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.err_timeout    = err_q;
endmodule

// File: doc/dlbf_slave_rdctrl.md
# dlbf_slave_rdctrl

Readback sequencer for the DLBF slave receive RAM, running entirely in the `bram_clk_a` domain. On a start command it pulses the slave reset, programs the iteration count, waits for the slave to report receive-done, then reads every received 64-bit word out of the RX RAM over the clock-domain-crossed port-B signals. Address and enable changes are paced so that each value settles through the CDC synchronisers before it is relied on. Read data is presented on a valid/ready stream for the PS-side readout logic.

## Interface
- `ADDR_W`, 16: RX RAM address width.
- `DATA_W`, 64: RX RAM data width.
- `SETTLE_CYC`, 8: cycles any `addrb_bram`/`enb_bram` change is held before the next dependent step (≥2).
- `RD_LAT`, 12: cycles from `enb_bram` rising to `doutb_bram` being valid (≥1).
- `RST_PULSE`, 16: `slave_rst_bram` high duration in cycles (≥1).
- `TIMEOUT_CYC`, 1048576: maximum wait in WAIT_CLR or WAIT_DONE before abort.

Ports:
- `bram_clk_a`  in  1  sole clock.
- `bram_rst_a_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle session start; ignored while `busy`.
- `niter_cfg`  in  12  iteration count, captured on an accepted `start`.
- `rxdone_bram`  in  1  synchronised slave receive-done.
- `rxram_counter_bram`  in  ADDR_W  synchronised count of words written into the RX RAM.
- `doutb_bram`  in  DATA_W  synchronised RX RAM read data.
- `slave_rst_bram`  out  1  slave reset request.
- `niter_bram`  out  12  registered iteration count toward the slave.
- `addrb_bram`  out  ADDR_W  RX RAM read address.
- `enb_bram`  out  1  RX RAM port-B enable.
- `web_bram`  out  1  port-B write enable; constant 0.
- `m_data`  out  DATA_W  readout word.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  consumer accepts the word.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a session finishes.
- `err_timeout`  out  1  sticky timeout flag; cleared on an accepted `start`.

## Operation
- Reset value of every output is 0, and the FSM is in IDLE. Reset is asynchronous: it aborts any state immediately.
- IDLE: an accepted `start` captures `niter_cfg` into `niter_bram`, clears `err_timeout`, and enters RESET.
- RESET: `slave_rst_bram`=1 for exactly `RST_PULSE` cycles, then → WAIT_CLR.
- WAIT_CLR: waits for `rxdone_bram`=0. This discards a stale done level still in the synchroniser from the previous session. Then → WAIT_DONE.
- WAIT_DONE: on the first cycle `rxdone_bram`=1, snapshot `rxram_counter_bram` into `nwords` and set `addrb_bram`=0.
  - If `nwords`=0 → FIN.
  - Otherwise → ADDR.
- ADDR: hold for `SETTLE_CYC` cycles with `enb_bram`=0, then → READ.
- READ: `enb_bram`=1 for `RD_LAT` cycles. At the edge ending the last cycle, register `doutb_bram` into `m_data` and → OUT.
- OUT: `m_valid`=1 and `enb_bram` stays 1. `m_data` is stable until `m_valid`&&`m_ready`. On the handshake edge, `m_valid`→0 and → CLOSE.
- CLOSE: `enb_bram`=0 for `SETTLE_CYC` cycles.
  - If `addrb_bram` = `nwords`−1 → FIN.
  - Otherwise `addrb_bram` += 1 and → ADDR. The address only ever increments by 1, as the gray-coded crossing requires.
- FIN: `done`=1 for one cycle, then → IDLE. `addrb_bram` holds its last value.
- Timeout: a shared counter is cleared on entry to WAIT_CLR and to WAIT_DONE. When it reaches `TIMEOUT_CYC` in either state: `err_timeout`=1, no `done`, → IDLE.
- `start` while `busy` has no effect. `rxdone_bram` changes outside WAIT_CLR/WAIT_DONE are ignored. `rxram_counter_bram` is sampled only at the snapshot.
- A word count of 65535 is legal; the last address read is 65534.

## Timing
- `start` edge → `slave_rst_bram`=1 one cycle later; `busy`=1 on the same cycle.
- With `m_ready` tied high, one word occupies 2·`SETTLE_CYC`+`RD_LAT`+1 cycles (29 with defaults). The first `m_valid` rises `SETTLE_CYC`+`RD_LAT` cycles after the snapshot edge.
- `m_valid` never rises in the cycle after a handshake. At most one word is outstanding; there is no buffering.
- `enb_bram` is never high in ADDR or CLOSE. `addrb_bram` never changes while `enb_bram`=1.
- Last handshake → `done` pulse after `SETTLE_CYC`+1 cycles.

## Test plan
- Basic session: `niter_cfg`=5, `start`. Slave model raises done with counter=4 and RAM[i]=0xA5A5_0000_0000_0000+i, `m_ready`=1. Required:
  - `slave_rst_bram` high for 16 cycles and `niter_bram`=5.
  - Four words 0xA5A5…0000 to …0003, 29 cycles apart.
  - `done` pulse, then `busy`=0.
- Backpressure: counter=3, `m_ready` held low for 50 cycles on word 1. Required: `m_data` and `m_valid` stable throughout; `enb_bram`=1 and `addrb_bram`=1 held; word order preserved.
- Zero and stale done: `rxdone_bram` held high at `start`, dropped 40 cycles later, raised again with counter=0. Required: no WAIT_DONE exit before the drop; no `m_valid`; `done` one cycle after the snapshot.
- Timeout: `TIMEOUT_CYC`=100, `rxdone_bram` never rises. Required: `err_timeout`=1 at cycle 100 of WAIT_DONE, no `done`, IDLE. A new `start` clears `err_timeout`.
- Mid-operation reset: assert `bram_rst_a_n`=0 during READ of word 2. Required: all outputs 0 asynchronously. A subsequent `start` replays the full session from address 0.
- `start` pulsed during READ with `niter_cfg`=9. Required: ignored; `niter_bram` unchanged and the sequence is undisturbed.
